// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// FSM state encodings, default operand width and iteration-counter sizing.
package mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_DZERO = 3'd5;

  // Iteration counter counts 0..width-1, so $clog2(width) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation: out = en ? -in : in.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider sharing one
// 2*WIDTH+1 bit accumulator; results land in Hi/Lo with a one-cycle Done pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg;
  // Layout: {hi[WIDTH-1:0], lo[WIDTH-1:0], booth_q}; divide keeps remainder in hi, quotient in lo.
  logic [2*WIDTH:0]    acc_reg;
  logic [WIDTH-1:0]    mcand_reg;
  logic                sign_a_reg, sign_b_reg;

  logic [WIDTH-1:0]    acc_hi, acc_lo;
  logic [WIDTH-1:0]    abs_a, abs_b, quo_fixed, rem_fixed;
  logic [WIDTH:0]      booth_sum;
  logic [2*WIDTH:0]    booth_next;
  logic [WIDTH:0]      div_shift, div_diff;
  logic [2*WIDTH:0]    div_next;

  assign acc_hi = acc_reg[2*WIDTH:WIDTH+1];
  assign acc_lo = acc_reg[WIDTH:1];
  assign Busy   = (state_reg != S_IDLE);

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.en(OpA[WIDTH-1]), .in(OpA), .out(abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.en(OpB[WIDTH-1]), .in(OpB), .out(abs_b));
  mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (.en(sign_a_reg ^ sign_b_reg), .in(acc_lo), .out(quo_fixed));
  mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (.en(sign_a_reg), .in(acc_hi), .out(rem_fixed));

  // Booth add/sub is done one bit wider so a most-negative multiplicand cannot overflow.
  always_comb begin
    booth_sum = {acc_hi[WIDTH-1], acc_hi};
    case (acc_reg[1:0])
      2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand_reg[WIDTH-1], mcand_reg};
      2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand_reg[WIDTH-1], mcand_reg};
      default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
    endcase
    booth_next = {booth_sum, acc_reg[WIDTH:1]};
  end

  always_comb begin
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1, 1'b0};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0, 1'b0};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (MultStart)               state_next = S_MULT;
        else if (DivStart && OpB == '0) state_next = S_DZERO;
        else if (DivStart)           state_next = S_DIV;
      end
      S_MULT:  if (cnt_reg == LAST_STEP) state_next = S_DONE;
      S_DIV:   if (cnt_reg == LAST_STEP) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      // DZERO is held for two cycles; the counter marks the second one.
      S_DZERO: if (cnt_reg != '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      Hi         <= '0;
      Lo         <= '0;
      Done       <= 1'b0;
      DivZero    <= 1'b0;
    end else begin
      state_reg <= state_next;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          if (MultStart) begin
            mcand_reg <= OpA;
            acc_reg   <= {{WIDTH{1'b0}}, OpB, 1'b0};
          end else if (DivStart) begin
            if (OpB == '0) begin
              DivZero <= 1'b1;
            end else begin
              mcand_reg  <= abs_b;
              acc_reg    <= {{WIDTH{1'b0}}, abs_a, 1'b0};
              sign_a_reg <= OpA[WIDTH-1];
              sign_b_reg <= OpB[WIDTH-1];
            end
          end
        end
        S_MULT: begin
          acc_reg <= booth_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_FIX: acc_reg <= {rem_fixed, quo_fixed, 1'b0};
        S_DONE: begin
          Hi   <= acc_hi;
          Lo   <= acc_lo;
          Done <= 1'b1;
        end
        S_DZERO: cnt_reg <= cnt_reg + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every Done/DivZero pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         MultStart = 1'b0;
  logic         DivStart = 1'b0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic [W-1:0] Hi, Lo;
  logic         Busy, Done, DivZero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string        name;
    bit           dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           at;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .MultStart(MultStart), .DivStart(DivStart),
    .OpA(OpA), .OpB(OpB), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (Reset_n && (Done || DivZero)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: Done=%b DivZero=%b at cycle %0d", Done, DivZero, cyc);
      end else begin
        e = sb.pop_front();
        $display("%s: Done=%b DivZero=%b Hi=%h Lo=%h cycle=%0d", e.name, Done, DivZero, Hi, Lo, cyc);
        check({e.name, "_kind"}, {62'd0, Done, DivZero}, {62'd0, !e.dz, e.dz});
        check({e.name, "_hilo"}, {Hi, Lo}, {e.hi, e.lo});
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  // Call at a negedge; start is sampled on the following posedge.
  task automatic launch(input string name, input bit m, input bit d,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit dz, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int lat);
    exp_t e;
    e.name = name; e.dz = dz; e.hi = ehi; e.lo = elo; e.at = cyc + 1 + lat;
    sb.push_back(e);
    MultStart = m; DivStart = d; OpA = a; OpB = b;
    @(posedge Clock);
    #1;
    MultStart = 1'b0;
    DivStart  = 1'b0;
  endtask

  task automatic wait_resp(input string name, output int busy_n);
    bit hit;
    hit = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge Clock);
      if (Busy) busy_n++;
      if (Done || DivZero) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no response, expected one within 100 cycles", name);
    end
    for (int i = 0; i < 10 && Busy; i++) @(negedge Clock);
  endtask

  initial begin
    int bn;
    repeat (3) @(negedge Clock);
    check("reset_state", {Hi, Lo}, 64'd0);
    check("reset_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    Reset_n = 1'b1;
    @(negedge Clock);

    launch("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    wait_resp("mul_7_m3", bn);
    check("mul_busy_cycles", 64'(bn), 64'd33);

    launch("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0, 33);
    wait_resp("mul_min_min", bn);
    launch("mul_m1_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, 32'h1, 33);
    wait_resp("mul_m1_m1", bn);

    launch("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    wait_resp("div_m7_2", bn);
    check("div_busy_cycles", 64'(bn), 64'd34);

    launch("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 0, 32'h1, 32'hFFFF_FFFD, 34);
    wait_resp("div_7_m2", bn);
    launch("div_overflow", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 34);
    wait_resp("div_overflow", bn);
    launch("div_100_7", 0, 1, 32'd100, 32'd7, 0, 32'd2, 32'd14, 34);
    wait_resp("div_100_7", bn);
    launch("div_m100_m7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'hFFFF_FFFE, 32'd14, 34);
    wait_resp("div_m100_m7", bn);

    // Divide by zero leaves the previous result in place.
    launch("div_zero", 0, 1, 32'd5, 32'd0, 1, 32'hFFFF_FFFE, 32'd14, 0);
    wait_resp("div_zero", bn);
    repeat (3) @(negedge Clock);
    check("dz_hilo_kept", {Hi, Lo}, {32'hFFFF_FFFE, 32'd14});

    launch("both_starts", 1, 1, 32'd6, 32'd5, 0, 32'h0, 32'd30, 33);
    wait_resp("both_starts", bn);

    // Mid-multiply DivStart (with a zero divisor) and operand changes must be ignored.
    launch("mul_ignore_div", 1, 0, 32'd1234, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 33);
    repeat (10) @(negedge Clock);
    DivStart = 1'b1; OpA = 32'd0; OpB = 32'd0;
    @(negedge Clock);
    DivStart = 1'b0; OpA = 32'd77;
    wait_resp("mul_ignore_div", bn);

    // Asynchronous reset in the middle of a divide.
    OpA = 32'd50; OpB = 32'd3; DivStart = 1'b1;
    @(posedge Clock);
    #1 DivStart = 1'b0;
    repeat (9) @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {Hi, Lo}, 64'd0);
    check("async_reset_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    launch("mul_after_reset", 1, 0, 32'd9, 32'd9, 0, 32'h0, 32'd81, 33);
    wait_resp("mul_after_reset", bn);

    repeat (5) @(negedge Clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit that responds to the control FSM's `flagMultStart`/`flagDivStart` strobes. It takes operands from registers A and B and computes the 64-bit product or the quotient/remainder pair. It reports completion with a one-cycle `Done` pulse, after which the control FSM writes Hi/Lo via `flagRegHighW`/`flagRegLowW`. It sits in the datapath beside the ALU and is the responder end of the control unit's mult/div handshake.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥4; Hi/Lo are each `WIDTH` bits.
- `Clock`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `MultStart`  in  1  start signed multiply; sampled only in IDLE.
- `DivStart`  in  1  start signed divide; sampled only in IDLE.
- `OpA`  in  WIDTH  multiplicand / dividend (register A).
- `OpB`  in  WIDTH  multiplier / divisor (register B).
- `Hi`  out  WIDTH  product upper half / remainder; registered.
- `Lo`  out  WIDTH  product lower half / quotient; registered.
- `Busy`  out  1  high while not IDLE.
- `Done`  out  1  one-cycle pulse; Hi/Lo are valid from this cycle on.
- `DivZero`  out  1  one-cycle pulse: divide requested with `OpB`=0.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE, DZERO. Encoded in package.
- Reset (async, any state): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivZero=0; iteration counter=0; working regs cleared. Any operation in flight is abandoned.
- IDLE, `MultStart`=1: capture `OpA`/`OpB`, go to MULT. `MultStart` takes priority if both starts are high.
- IDLE, `DivStart`=1, `OpB`≠0: capture `|OpA|`, `|OpB|`, and the two sign bits, then go to DIV.
- IDLE, `DivStart`=1, `OpB`=0: go to DZERO. Hi/Lo are not modified.
- Starts outside IDLE are ignored and are not queued.
- MULT: radix-2 Booth, one step per cycle, WIDTH steps. Accumulator is 2·WIDTH+1 bits and shifts arithmetically. After step WIDTH-1, go to DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH steps, then go to FIX.
- FIX: negate the quotient if the operand signs differ. Give the remainder the sign of the dividend. Go to DONE.
- DONE: load Hi/Lo from the working regs, assert `Done`, return to IDLE.
- DZERO: assert `DivZero` for one cycle, return to IDLE. `Done` stays 0.
- Overflow case (−2^(WIDTH−1)) / (−1): Lo=0x80000000, Hi=0 for WIDTH=32. No exception is raised.
- All arithmetic is two's complement. Product is exact in 2·WIDTH bits.

## Timing
- Start sampled high at edge 0 → state MULT/DIV from edge 0.
- Multiply: WIDTH iteration edges, DONE entered at edge WIDTH. `Done` and new Hi/Lo are visible after edge WIDTH+1, i.e. a 33-cycle latency for WIDTH=32.
- Divide: one extra FIX cycle gives a 34-cycle latency for WIDTH=32.
- Divide by zero: `DivZero` is high during the cycle after edge 0; state returns to IDLE at edge 2.
- `Busy` is high from edge 0 until the edge that returns the FSM to IDLE.
- A start may be accepted in the cycle immediately after `Done` (back-to-back operation).
- Operand changes after the start edge do not affect the result.
- Hi/Lo hold their last completed result indefinitely. They change only in DONE.

## Structure
- Package `mult_div_pkg`: state enum, `WIDTH_DEFAULT`=32, and the counter width `$clog2(WIDTH)`.
- One sub-module, `mdu_negate`: combinational conditional two's-complement negation (`en`, `in` → `out`). It is instantiated for operand absolute values and for quotient/remainder sign fix.
- Everything else lives in one sequential FSM+datapath process and one next-state process.

## Test plan
- Multiply: A=7, B=−3 → after 33 cycles `Done`=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; `Busy` high for exactly 33 cycles.
- Multiply: A=0x80000000, B=0x80000000 → Hi=0x40000000, Lo=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF → Hi=0, Lo=1.
- Divide: A=−7, B=2 → 34-cycle latency, Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1). Then A=7, B=−2 → Lo=−3, Hi=1.
- Divide by zero: A=5, B=0 → `DivZero` pulses one cycle, `Done` never rises, Hi/Lo keep the prior result.
- Priority and ignore: `MultStart` and `DivStart` both high → multiply result. A `DivStart` pulse mid-multiply has no effect.
- `Reset_n` low at cycle 10 of a divide → all outputs 0 immediately. A new multiply after release completes with the correct result.
